// File: rtl/fc_pkg.sv
// Shared definitions for the pipeline flow controller: channel FSM encoding,
// default stage map and a stage-range mask helper.
package fc_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_WAIT  = 2'd1,
    CH_DRAIN = 2'd2
  } ch_state_e;

  localparam int         DEF_N_STAGES   = 5;
  localparam int         DEF_N_CH       = 2;
  localparam int         DEF_N_RD       = 2;
  localparam logic [7:0] DEF_CH_STAGE   = {4'd2, 4'd0};
  localparam logic [7:0] DEF_RD_STAGE   = {4'd2, 4'd1};
  localparam int         DEF_LU_STAGE   = 1;
  localparam int         DEF_LU_BUBBLES = 1;

  // Bits 0..k set; k < 0 yields an empty mask.
  function automatic logic [15:0] low_mask(input int k);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[i] = (i <= k);
    end
    return m;
  endfunction

endpackage

// File: rtl/fc_miss_chan.sv
// One memory channel miss tracker: IDLE/WAIT/DRAIN FSM with registered busy and
// discard, plus a combinational stall request that covers the miss cycle itself.
module fc_miss_chan
  import fc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic hit_i,
  input  logic ready_i,
  input  logic wait_i,
  input  logic flush_i,
  output logic stall_o,
  output logic busy_o,
  output logic discard_o
);

  ch_state_e state_q;
  logic      busy_q;
  logic      discard_q;

  // ready_i is honoured even while the core is frozen by wait_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      busy_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (req_i && !hit_i && !wait_i) begin
            state_q <= CH_WAIT;
            busy_q  <= 1'b1;
          end
        end
        CH_WAIT: begin
          if (ready_i) begin
            state_q <= CH_IDLE;
            busy_q  <= 1'b0;
          end else if (flush_i && !wait_i) begin
            state_q   <= CH_DRAIN;
            discard_q <= 1'b1;
          end
        end
        CH_DRAIN: begin
          if (ready_i) begin
            state_q   <= CH_IDLE;
            busy_q    <= 1'b0;
            discard_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= CH_IDLE;
          busy_q    <= 1'b0;
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      if (state_q == CH_IDLE) begin
        stall_o = req_i && !hit_i;
      end else if (state_q == CH_WAIT || state_q == CH_DRAIN) begin
        stall_o = !ready_i;
      end
    end
  end

  assign busy_o    = busy_q;
  assign discard_o = discard_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline stall/flush controller: merges cache-miss stalls, oldest-first redirect
// arbitration and load-use bubble insertion into per-stage stall and flush bits.
module pipe_flow_ctrl
  import fc_pkg::*;
#(
  parameter int                N_STAGES   = DEF_N_STAGES,
  parameter int                N_CH       = DEF_N_CH,
  parameter logic [4*N_CH-1:0] CH_STAGE   = DEF_CH_STAGE,
  parameter int                N_RD       = DEF_N_RD,
  parameter logic [4*N_RD-1:0] RD_STAGE   = DEF_RD_STAGE,
  parameter int                LU_STAGE   = DEF_LU_STAGE,
  parameter int                LU_BUBBLES = DEF_LU_BUBBLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_wait_i,
  input  logic [N_CH-1:0]      ch_req_i,
  input  logic [N_CH-1:0]      ch_hit_i,
  input  logic [N_CH-1:0]      ch_ready_i,
  input  logic [N_RD-1:0]      redir_valid_i,
  input  logic [32*N_RD-1:0]   redir_pc_i,
  input  logic                 lu_req_i,
  output logic [N_RD-1:0]      redir_ack_o,
  output logic                 fc_jump_flag_o,
  output logic [31:0]          fc_jump_pc_o,
  output logic [N_STAGES-1:0]  fc_stall_o,
  output logic [N_STAGES-1:0]  fc_flush_o,
  output logic [N_CH-1:0]      ch_busy_o,
  output logic [N_CH-1:0]      ch_discard_o
);

  localparam bit LU_HAS_NXT = (LU_STAGE + 1) < N_STAGES;
  localparam int LU_NXT     = LU_HAS_NXT ? LU_STAGE + 1 : LU_STAGE;

  logic [N_CH-1:0]     chan_stall;
  logic [N_CH-1:0]     chan_busy;
  logic [N_CH-1:0]     chan_discard;
  logic [N_STAGES-1:0] stall_base;
  logic [N_STAGES-1:0] stall_pre;
  logic [N_STAGES-1:0] stall_all;
  logic [N_STAGES-1:0] flush_all;
  logic [N_STAGES-1:0] lu_mask;
  logic [15:0]         mask_tmp;
  logic                rd_any;
  int                  rd_win;
  int                  rd_stage;
  logic                rd_ack;
  logic                lu_raw;
  logic                lu_kill;
  logic                lu_act;
  logic [2:0]          lu_cnt_q;
  logic [2:0]          lu_cnt_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    localparam int CS = int'(CH_STAGE[4*c +: 4]);
    fc_miss_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .req_i     (ch_req_i[c]),
      .hit_i     (ch_hit_i[c]),
      .ready_i   (ch_ready_i[c]),
      .wait_i    (core_wait_i),
      .flush_i   (fc_flush_o[CS]),
      .stall_o   (chan_stall[c]),
      .busy_o    (chan_busy[c]),
      .discard_o (chan_discard[c])
    );
  end

  always_comb begin
    stall_base = '0;
    mask_tmp   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (chan_stall[c]) begin
        mask_tmp   = low_mask(int'(CH_STAGE[4*c +: 4]));
        stall_base = stall_base | mask_tmp[N_STAGES-1:0];
      end
    end
    if (core_wait_i) begin
      stall_base = '1;
    end

    mask_tmp = low_mask(LU_STAGE);
    lu_mask  = mask_tmp[N_STAGES-1:0];
    lu_raw   = lu_req_i && (lu_cnt_q < 3'(LU_BUBBLES));
    stall_pre = stall_base | (lu_raw ? lu_mask : '0);

    // Oldest stage wins; strict compare keeps the lower index on ties.
    rd_any   = 1'b0;
    rd_win   = 0;
    rd_stage = 0;
    for (int i = 0; i < N_RD; i++) begin
      if (redir_valid_i[i] && (!rd_any || int'(RD_STAGE[4*i +: 4]) > rd_stage)) begin
        rd_any   = 1'b1;
        rd_win   = i;
        rd_stage = int'(RD_STAGE[4*i +: 4]);
      end
    end
    // Load-use stalls only reach LU_STAGE, so stall_pre is exact at any stage that could suppress it.
    rd_ack  = rd_any && !stall_pre[rd_stage];
    lu_kill = rd_ack && (rd_stage > LU_STAGE);
    lu_act  = lu_raw && !lu_kill;

    stall_all = stall_base | (lu_act ? lu_mask : '0);
    flush_all = '0;
    if (rd_ack) begin
      mask_tmp  = low_mask(rd_stage - 1);
      flush_all = mask_tmp[N_STAGES-1:0];
    end
    if (lu_act) begin
      flush_all[LU_STAGE] = 1'b1;
    end

    lu_cnt_d = lu_cnt_q;
    if (lu_kill || !stall_all[LU_STAGE]) begin
      lu_cnt_d = 3'd0;
    end else if (lu_act && !(LU_HAS_NXT && stall_all[LU_NXT])) begin
      lu_cnt_d = lu_cnt_q + 3'd1;
    end

    redir_ack_o    = '0;
    fc_jump_flag_o = 1'b0;
    fc_jump_pc_o   = '0;
    fc_stall_o     = '0;
    fc_flush_o     = '0;
    ch_busy_o      = '0;
    ch_discard_o   = '0;
    if (!rst) begin
      redir_ack_o[rd_win] = rd_ack;
      fc_jump_flag_o      = rd_ack;
      fc_jump_pc_o        = rd_ack ? redir_pc_i[rd_win*32 +: 32] : 32'd0;
      fc_stall_o          = stall_all;
      fc_flush_o          = flush_all;
      ch_busy_o           = chan_busy;
      ch_discard_o        = chan_discard;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q <= 3'd0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Randomized and directed stimulus against a behavioural model; expected outputs are
// queued per cycle and a negedge monitor pops and compares them.
module tb_pipe_flow_ctrl;

  localparam int CHS [2] = '{0, 2};
  localparam int RDS [2] = '{1, 2};
  localparam int LUS = 1;
  localparam int LUB = 2;

  typedef struct packed {
    logic [1:0]  ack;
    logic        jf;
    logic [31:0] jpc;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [1:0]  busy;
    logic [1:0]  disc;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_wait_i;
  logic [1:0]  ch_req_i, ch_hit_i, ch_ready_i;
  logic [1:0]  redir_valid_i;
  logic [63:0] redir_pc_i;
  logic        lu_req_i;
  logic [1:0]  redir_ack_o;
  logic        fc_jump_flag_o;
  logic [31:0] fc_jump_pc_o;
  logic [4:0]  fc_stall_o, fc_flush_o;
  logic [1:0]  ch_busy_o, ch_discard_o;

  int checks   = 0;
  int failures = 0;
  int mon_cyc  = 0;
  out_t exp_q[$];

  // Model state: miss in flight, refill doomed to be dropped, bubbles issued so far.
  bit [1:0] m_pend;
  bit [1:0] m_doom;
  int       m_lu;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(
    .N_STAGES(5), .N_CH(2), .CH_STAGE({4'd2, 4'd0}), .N_RD(2),
    .RD_STAGE({4'd2, 4'd1}), .LU_STAGE(1), .LU_BUBBLES(2)
  ) dut (
    .clk(clk), .rst(rst), .core_wait_i(core_wait_i),
    .ch_req_i(ch_req_i), .ch_hit_i(ch_hit_i), .ch_ready_i(ch_ready_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i), .lu_req_i(lu_req_i),
    .redir_ack_o(redir_ack_o), .fc_jump_flag_o(fc_jump_flag_o), .fc_jump_pc_o(fc_jump_pc_o),
    .fc_stall_o(fc_stall_o), .fc_flush_o(fc_flush_o),
    .ch_busy_o(ch_busy_o), .ch_discard_o(ch_discard_o)
  );

  function automatic logic [4:0] msk(input int k);
    return (k < 0) ? 5'd0 : 5'((1 << (k + 1)) - 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, mon_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("redirect", {redir_ack_o, fc_jump_flag_o, fc_jump_pc_o}, {e.ack, e.jf, e.jpc});
      chk("stall", 64'(fc_stall_o), 64'(e.stall));
      chk("flush", 64'(fc_flush_o), 64'(e.flush));
      chk("chan", {ch_busy_o, ch_discard_o}, {e.busy, e.disc});
      mon_cyc++;
    end
  end

  // Evaluate the model on the current inputs, queue the expectation, advance one clock.
  task automatic apply();
    out_t       e;
    int         top, st, win;
    bit         any, ack, kill, lu_on;
    logic [4:0] stall, flush;
    e = '0; ack = 0; win = 0;
    if (rst) begin
      m_pend = 0; m_doom = 0; m_lu = 0;
    end else begin
      top = -1;
      for (int c = 0; c < 2; c++) begin
        if ((!m_pend[c] && ch_req_i[c] && !ch_hit_i[c]) || (m_pend[c] && !ch_ready_i[c]))
          if (CHS[c] > top) top = CHS[c];
      end
      stall = core_wait_i ? 5'h1f : msk(top);
      lu_on = lu_req_i && (m_lu < LUB);
      any = 0; st = 0;
      for (int i = 0; i < 2; i++) begin
        if (redir_valid_i[i] && (!any || RDS[i] > st)) begin
          any = 1; st = RDS[i]; win = i;
        end
      end
      ack  = any && !((stall | (lu_on ? msk(LUS) : 5'd0)) >> st & 5'd1);
      kill = ack && (st > LUS);
      if (kill) lu_on = 0;
      if (lu_on) stall = stall | msk(LUS);
      flush = ack ? msk(st - 1) : 5'd0;
      if (lu_on) flush = flush | 5'(1 << LUS);
      e.ack   = ack ? 2'(1 << win) : 2'd0;
      e.jf    = ack;
      e.jpc   = ack ? redir_pc_i[win*32 +: 32] : 32'd0;
      e.stall = stall;
      e.flush = flush;
      e.busy  = m_pend;
      e.disc  = m_doom;
      for (int c = 0; c < 2; c++) begin
        if (!m_pend[c]) begin
          if (ch_req_i[c] && !ch_hit_i[c] && !core_wait_i) m_pend[c] = 1;
        end else if (ch_ready_i[c]) begin
          m_pend[c] = 0; m_doom[c] = 0;
        end else if (flush[CHS[c]] && !core_wait_i) begin
          m_doom[c] = 1;
        end
      end
      if (kill || !stall[LUS]) m_lu = 0;
      else if (lu_on && !stall[LUS+1]) m_lu++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (ack) redir_valid_i[win] = 1'b0;
  endtask

  task automatic idle(input int n);
    core_wait_i = 0; ch_req_i = 0; ch_hit_i = 0; ch_ready_i = 0; lu_req_i = 0;
    repeat (n) apply();
  endtask

  initial begin
    rst = 1; core_wait_i = 0; ch_req_i = 0; ch_hit_i = 0; ch_ready_i = 0;
    redir_valid_i = 0; redir_pc_i = 0; lu_req_i = 0;
    m_pend = 0; m_doom = 0; m_lu = 0;
    @(posedge clk);
    #1;
    repeat (3) apply();
    rst = 0;
    idle(2);

    // Instruction miss, refill four cycles later.
    ch_req_i = 2'b01; apply(); ch_req_i = 0;
    repeat (3) apply();
    ch_ready_i = 2'b01; apply(); ch_ready_i = 0;
    idle(2);

    // Two redirects at once: stage 2 first, then stage 1.
    redir_pc_i = {32'h200, 32'h100}; redir_valid_i = 2'b11;
    apply(); apply();
    idle(1);

    // Data miss blocks a stage-1 redirect until the refill returns.
    ch_req_i = 2'b10; apply(); ch_req_i = 0; apply();
    redir_pc_i[31:0] = 32'h80; redir_valid_i[0] = 1'b1;
    repeat (3) apply();
    ch_ready_i = 2'b10; apply(); ch_ready_i = 0;
    idle(2);

    // Instruction miss turned into a drain by a stage-2 redirect.
    ch_req_i = 2'b01; apply(); ch_req_i = 0;
    redir_pc_i[63:32] = 32'h300; redir_valid_i[1] = 1'b1;
    repeat (3) apply();
    ch_ready_i = 2'b01; apply(); ch_ready_i = 0;
    idle(2);

    // Load-use held: two bubbles then released.
    lu_req_i = 1; repeat (3) apply();
    idle(2);

    // Reset mid-WAIT; the late refill must be ignored.
    ch_req_i = 2'b01; apply(); ch_req_i = 0; apply();
    rst = 1; apply(); rst = 0; apply();
    ch_ready_i = 2'b01; apply(); ch_ready_i = 0;
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      core_wait_i = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < 2; c++) begin
        ch_req_i[c]   = ($urandom_range(0, 2) == 0);
        ch_hit_i[c]   = ($urandom_range(0, 1) == 0);
        ch_ready_i[c] = m_pend[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (!redir_valid_i[i] && $urandom_range(0, 5) == 0) begin
          redir_valid_i[i] = 1'b1;
          redir_pc_i[i*32 +: 32] = $urandom & 32'hffff_fffc;
        end
      end
      lu_req_i = lu_req_i ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      apply();
    end
    rst = 0;
    idle(2);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
